// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared types and constants for the pipeline hazard unit.
//             Provides the producer slot record, the "no forward" select
//             encoding, the default register-index width and the producer
//             match predicate used by every priority search.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Default register-index width (32 architectural registers).
    localparam int REG_IDX_W_DEFAULT = 5;

    // Slot records carry rd at a fixed, generous width so the typedef does
    // not depend on the instantiating module's parameter; narrower indices
    // are zero-extended on the way in.
    localparam int REG_IDX_W_MAX = 8;

    // Forward-select value meaning "take the operand as read in ID".
    localparam int FWD_NONE = 0;

    typedef struct packed {
        logic                     valid;
        logic [REG_IDX_W_MAX-1:0] rd;
        logic                     wen;
        logic                     is_load;
    } slot_t;

    // A producer only counts when it is real, writes a non-zero rd equal to
    // the source index, and the consumer actually reads that source.
    function automatic logic slot_matches(
        input slot_t                    s,
        input logic [REG_IDX_W_MAX-1:0] src,
        input logic                     used
    );
        return s.valid && s.wen && used && (s.rd == src) && (s.rd != '0);
    endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_fwd_match
//  Purpose  : Youngest-producer priority search for one source operand.
//             Scans an ordered list of producer slots (index 0 = youngest)
//             and reports the lowest-indexed slot that matches the source.
//  Ports    : src_idx      in   zero-extended source register index
//             src_used     in   source is actually read
//             slots        in   candidate producer slots, youngest first
//             hit          out  some slot matches
//             hit_pos      out  index of the youngest matching slot
//             hit_is_load  out  that producer is a load
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_match
    import hazard_pkg::*;
#(
    parameter int N_SLOTS = 2,
    parameter int POS_W   = 2
) (
    input  logic [REG_IDX_W_MAX-1:0] src_idx,
    input  logic                     src_used,
    input  slot_t                    slots [N_SLOTS],
    output logic                     hit,
    output logic [POS_W-1:0]         hit_pos,
    output logic                     hit_is_load
);

    // Scan oldest to youngest so the last assignment (lowest index) wins.
    always_comb begin
        hit         = 1'b0;
        hit_pos     = '0;
        hit_is_load = 1'b0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (slot_matches(slots[i], src_idx, src_used)) begin
                hit         = 1'b1;
                hit_pos     = POS_W'(i);
                hit_is_load = slots[i].is_load;
            end
        end
    end

endmodule : hazard_fwd_match
`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_unit
//  Purpose  : Data/control hazard detection for an in-order pipeline.
//             Tracks producers in EXE (slot 0) and the FWD_STAGES downstream
//             stages, selects EXE operand forwarding, requests WB-to-ID
//             bypass, raises load-use stalls and flushes on redirect.
//  Ports    : clk, rst                  clock, async active-low reset
//             id_valid                  ID holds a real instruction
//             id_rs1/rs2_idx, _used     ID sources and read flags
//             id_rd_idx, id_rd_wen      ID destination and write enable
//             id_is_load                ID instruction is a load
//             ex_redirect               taken branch/jump resolved in EXE
//             stall                     hold PC and D, bubble into E
//             flush_d, flush_e          invalidate D and E registers
//             id_rs1/rs2_wb_bypass      use WB data instead of regfile in ID
//             ex_rs1/rs2_fwd_sel        0 = none, k = forward from slot k
//             stall_cnt, flush_cnt      performance counters
//  Config   : HAZARD_PERF_EN - when defined, stall_cnt/flush_cnt count
//             stall and redirect cycles; otherwise both are tied to 0.
//  Notes    : LD_AVAIL_STAGE must lie in 1..FWD_STAGES.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_IDX_W      = REG_IDX_W_DEFAULT,
    parameter int FWD_STAGES     = 2,
    parameter int LD_AVAIL_STAGE = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              id_valid,
    input  logic [REG_IDX_W-1:0]              id_rs1_idx,
    input  logic [REG_IDX_W-1:0]              id_rs2_idx,
    input  logic                              id_rs1_used,
    input  logic                              id_rs2_used,
    input  logic [REG_IDX_W-1:0]              id_rd_idx,
    input  logic                              id_rd_wen,
    input  logic                              id_is_load,
    input  logic                              ex_redirect,
    output logic                              stall,
    output logic                              flush_d,
    output logic                              flush_e,
    output logic                              id_rs1_wb_bypass,
    output logic                              id_rs2_wb_bypass,
    output logic [$clog2(FWD_STAGES+1)-1:0]   ex_rs1_fwd_sel,
    output logic [$clog2(FWD_STAGES+1)-1:0]   ex_rs2_fwd_sel,
    output logic [31:0]                       stall_cnt,
    output logic [31:0]                       flush_cnt
);

    localparam int c_sel_w    = $clog2(FWD_STAGES + 1);
    localparam int c_id_pos_w = $clog2(FWD_STAGES + 2);

    // ------------------------------------------------------------------
    // Slot pipeline: r_slot[0] = EXE, r_slot[FWD_STAGES] = WB
    // ------------------------------------------------------------------
    slot_t                r_slot [FWD_STAGES+1];
    logic [REG_IDX_W-1:0] r_ex_rs1_idx;
    logic [REG_IDX_W-1:0] r_ex_rs2_idx;
    logic                 r_ex_rs1_used;
    logic                 r_ex_rs2_used;

    slot_t                w_ex_cand [FWD_STAGES];
    slot_t                w_slot0_next;
    logic                 w_slot0_load;

    logic [REG_IDX_W_MAX-1:0] w_id_rs1_ext;
    logic [REG_IDX_W_MAX-1:0] w_id_rs2_ext;
    logic [REG_IDX_W_MAX-1:0] w_ex_rs1_ext;
    logic [REG_IDX_W_MAX-1:0] w_ex_rs2_ext;

    logic                  w_ex1_hit, w_ex2_hit;
    logic [c_sel_w-1:0]    w_ex1_pos, w_ex2_pos;
    logic                  w_unused_ex1_ld, w_unused_ex2_ld;
    logic                  w_id1_hit, w_id2_hit;
    logic [c_id_pos_w-1:0] w_id1_pos, w_id2_pos;
    logic                  w_id1_ld, w_id2_ld;
    logic                  w_ld_use1, w_ld_use2;

    assign w_id_rs1_ext = REG_IDX_W_MAX'(id_rs1_idx);
    assign w_id_rs2_ext = REG_IDX_W_MAX'(id_rs2_idx);
    assign w_ex_rs1_ext = REG_IDX_W_MAX'(r_ex_rs1_idx);
    assign w_ex_rs2_ext = REG_IDX_W_MAX'(r_ex_rs2_idx);

    // EXE operands can only be fed from slots downstream of EXE.
    always_comb begin
        for (int k = 0; k < FWD_STAGES; k++) begin
            w_ex_cand[k] = r_slot[k+1];
        end
    end

    // ------------------------------------------------------------------
    // Priority searches: EXE sources over slots 1..FWD_STAGES, ID sources
    // over slots 0..FWD_STAGES (youngest producer decides the load-use case)
    // ------------------------------------------------------------------
    hazard_fwd_match #(.N_SLOTS(FWD_STAGES), .POS_W(c_sel_w)) u_ex_rs1 (
        .src_idx     (w_ex_rs1_ext),
        .src_used    (r_ex_rs1_used),
        .slots       (w_ex_cand),
        .hit         (w_ex1_hit),
        .hit_pos     (w_ex1_pos),
        .hit_is_load (w_unused_ex1_ld)
    );

    hazard_fwd_match #(.N_SLOTS(FWD_STAGES), .POS_W(c_sel_w)) u_ex_rs2 (
        .src_idx     (w_ex_rs2_ext),
        .src_used    (r_ex_rs2_used),
        .slots       (w_ex_cand),
        .hit         (w_ex2_hit),
        .hit_pos     (w_ex2_pos),
        .hit_is_load (w_unused_ex2_ld)
    );

    hazard_fwd_match #(.N_SLOTS(FWD_STAGES + 1), .POS_W(c_id_pos_w)) u_id_rs1 (
        .src_idx     (w_id_rs1_ext),
        .src_used    (id_rs1_used),
        .slots       (r_slot),
        .hit         (w_id1_hit),
        .hit_pos     (w_id1_pos),
        .hit_is_load (w_id1_ld)
    );

    hazard_fwd_match #(.N_SLOTS(FWD_STAGES + 1), .POS_W(c_id_pos_w)) u_id_rs2 (
        .src_idx     (w_id_rs2_ext),
        .src_used    (id_rs2_used),
        .slots       (r_slot),
        .hit         (w_id2_hit),
        .hit_pos     (w_id2_pos),
        .hit_is_load (w_id2_ld)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The candidate list starts at slot 1, so the slot number is pos + 1.
    assign ex_rs1_fwd_sel = (r_slot[0].valid && w_ex1_hit) ? (w_ex1_pos + c_sel_w'(1))
                                                           : c_sel_w'(FWD_NONE);
    assign ex_rs2_fwd_sel = (r_slot[0].valid && w_ex2_hit) ? (w_ex2_pos + c_sel_w'(1))
                                                           : c_sel_w'(FWD_NONE);

    // A load sitting in slot s reaches slot s+1 by the time the ID consumer
    // enters EXE; stall while that slot still precedes load-data availability.
    assign w_ld_use1 = w_id1_hit && w_id1_ld && ((int'(w_id1_pos) + 1) < LD_AVAIL_STAGE);
    assign w_ld_use2 = w_id2_hit && w_id2_ld && ((int'(w_id2_pos) + 1) < LD_AVAIL_STAGE);

    // Redirect wins: the ID instruction is being flushed anyway.
    assign stall = id_valid && !ex_redirect && (w_ld_use1 || w_ld_use2);

    // Gated by reset so every output reads 0 while reset is held.
    assign flush_d = ex_redirect && rst;
    assign flush_e = ex_redirect && rst;

    assign id_rs1_wb_bypass = slot_matches(r_slot[FWD_STAGES], w_id_rs1_ext, id_rs1_used);
    assign id_rs2_wb_bypass = slot_matches(r_slot[FWD_STAGES], w_id_rs2_ext, id_rs2_used);

    // ------------------------------------------------------------------
    // Slot pipeline update
    // ------------------------------------------------------------------
    assign w_slot0_load = id_valid && !stall && !ex_redirect;

    always_comb begin
        w_slot0_next         = '0;
        w_slot0_next.valid   = w_slot0_load;
        w_slot0_next.rd      = REG_IDX_W_MAX'(id_rd_idx);
        w_slot0_next.wen     = id_rd_wen;
        w_slot0_next.is_load = id_is_load;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k <= FWD_STAGES; k++) begin
                r_slot[k] <= '0;
            end
            r_ex_rs1_idx  <= '0;
            r_ex_rs2_idx  <= '0;
            r_ex_rs1_used <= 1'b0;
            r_ex_rs2_used <= 1'b0;
        end else begin
            for (int k = 1; k <= FWD_STAGES; k++) begin
                r_slot[k] <= r_slot[k-1];
            end
            r_slot[0]     <= w_slot0_next;
            // Source fields are qualified by r_slot[0].valid, so they can
            // load unconditionally.
            r_ex_rs1_idx  <= id_rs1_idx;
            r_ex_rs2_idx  <= id_rs2_idx;
            r_ex_rs1_used <= id_rs1_used;
            r_ex_rs2_used <= id_rs2_used;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (ex_redirect) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule : pipe_hazard_unit
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_unit
//  Purpose  : Self-checking bench for pipe_hazard_unit: directed scenarios
//             plus randomized instruction streams compared against an
//             instruction-history reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_unit;

    localparam int W   = 5;
    localparam int F   = 2;
    localparam int LAS = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         id_valid = 1'b0;
    logic [W-1:0] id_rs1_idx = '0, id_rs2_idx = '0, id_rd_idx = '0;
    logic         id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic         id_rd_wen = 1'b0, id_is_load = 1'b0, ex_redirect = 1'b0;
    logic         stall, flush_d, flush_e, id_rs1_wb_bypass, id_rs2_wb_bypass;
    logic [1:0]   ex_rs1_fwd_sel, ex_rs2_fwd_sel;
    logic [31:0]  stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_hazard_unit #(.REG_IDX_W(W), .FWD_STAGES(F), .LD_AVAIL_STAGE(LAS)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid         (id_valid),
        .id_rs1_idx       (id_rs1_idx),
        .id_rs2_idx       (id_rs2_idx),
        .id_rs1_used      (id_rs1_used),
        .id_rs2_used      (id_rs2_used),
        .id_rd_idx        (id_rd_idx),
        .id_rd_wen        (id_rd_wen),
        .id_is_load       (id_is_load),
        .ex_redirect      (ex_redirect),
        .stall            (stall),
        .flush_d          (flush_d),
        .flush_e          (flush_e),
        .id_rs1_wb_bypass (id_rs1_wb_bypass),
        .id_rs2_wb_bypass (id_rs2_wb_bypass),
        .ex_rs1_fwd_sel   (ex_rs1_fwd_sel),
        .ex_rs2_fwd_sel   (ex_rs2_fwd_sel),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: history of instructions that entered EXE, newest
    // first (hist[0] = in EXE, hist[F] = in WB).
    // ------------------------------------------------------------------
    typedef struct {
        bit valid; int rd; bit wen; bit ld;
        int rs1; int rs2; bit u1; bit u2;
    } instr_t;

    instr_t hist [0:F];
    int     m_stall_cnt = 0;
    int     m_flush_cnt = 0;

    function automatic bit m_match(instr_t e, int src, bit used);
        return e.valid && e.wen && used && (e.rd == src) && (src != 0);
    endfunction

    function automatic bit m_stall();
        int srcs [2];
        bit used [2];
        if (!rst || !id_valid || ex_redirect) return 1'b0;
        srcs[0] = int'(id_rs1_idx); used[0] = id_rs1_used;
        srcs[1] = int'(id_rs2_idx); used[1] = id_rs2_used;
        for (int j = 0; j < 2; j++) begin
            for (int s = 0; s <= F; s++) begin
                if (m_match(hist[s], srcs[j], used[j])) begin
                    if (hist[s].ld && (s + 1 < LAS)) return 1'b1;
                    break;
                end
            end
        end
        return 1'b0;
    endfunction

    function automatic int m_ex_sel(bit second);
        int src;
        bit used;
        if (!hist[0].valid) return 0;
        src  = second ? hist[0].rs2 : hist[0].rs1;
        used = second ? hist[0].u2  : hist[0].u1;
        for (int k = 1; k <= F; k++) begin
            if (m_match(hist[k], src, used)) return k;
        end
        return 0;
    endfunction

    function automatic bit m_bypass(bit second);
        if (second) return m_match(hist[F], int'(id_rs2_idx), id_rs2_used);
        return m_match(hist[F], int'(id_rs1_idx), id_rs1_used);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int k = 0; k <= F; k++) hist[k] = '{default: 0};
                m_stall_cnt = 0;
                m_flush_cnt = 0;
            end else begin
                bit st;
                st = m_stall();
                if (st) m_stall_cnt++;
                if (ex_redirect) m_flush_cnt++;
                for (int k = F; k > 0; k--) hist[k] = hist[k-1];
                hist[0].valid = id_valid && !st && !ex_redirect;
                hist[0].rd    = int'(id_rd_idx);
                hist[0].wen   = id_rd_wen;
                hist[0].ld    = id_is_load;
                hist[0].rs1   = int'(id_rs1_idx);
                hist[0].rs2   = int'(id_rs2_idx);
                hist[0].u1    = id_rs1_used;
                hist[0].u2    = id_rs2_used;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive_id(input bit v, input int rs1, input bit u1, input int rs2,
                            input bit u2, input int rd, input bit wen, input bit ld);
        id_valid    = v;
        id_rs1_idx  = W'(rs1);
        id_rs1_used = u1;
        id_rs2_idx  = W'(rs2);
        id_rs2_used = u2;
        id_rd_idx   = W'(rd);
        id_rd_wen   = wen;
        id_is_load  = ld;
    endtask

    task automatic drive_idle();
        drive_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        ex_redirect = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive_idle();
        repeat (F + 1) next_cycle();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if ({stall, flush_d, flush_e, id_rs1_wb_bypass, id_rs2_wb_bypass,
             ex_rs1_fwd_sel, ex_rs2_fwd_sel} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0", {stall, flush_d, flush_e,
                     id_rs1_wb_bypass, id_rs2_wb_bypass, ex_rs1_fwd_sel, ex_rs2_fwd_sel});
        end
        n_tests++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_alu_forward();
        drain();
        drive_id(1'b1, 1, 1'b1, 2, 1'b1, 5, 1'b1, 1'b0);      // add x5,x1,x2
        next_cycle();
        drive_id(1'b1, 5, 1'b1, 1, 1'b1, 6, 1'b1, 1'b0);      // add x6,x5,x1
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL alu_no_stall: got %b expected 0", stall);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_tests++;
        if (ex_rs1_fwd_sel !== 2'd1 || ex_rs2_fwd_sel !== 2'd0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_fwd: got sel1=%0d sel2=%0d stall=%b expected 1/0/0",
                     ex_rs1_fwd_sel, ex_rs2_fwd_sel, stall);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (ex_rs1_fwd_sel !== 2'd0) begin
            n_fail++; $display("FAIL alu_fwd_one_cycle: got %0d expected 0", ex_rs1_fwd_sel);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        drain();
        drive_id(1'b1, 2, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1);      // lw x5,0(x2)
        next_cycle();
        drive_id(1'b1, 5, 1'b1, 0, 1'b1, 6, 1'b1, 1'b0);      // add x6,x5,x0
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL load_use_stall: got %b expected 1", stall);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b0 || ex_rs1_fwd_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL load_use_release: got stall=%b sel1=%0d expected 0/0",
                     stall, ex_rs1_fwd_sel);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_tests++;
        if (ex_rs1_fwd_sel !== 2'd2 || ex_rs2_fwd_sel !== 2'd0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_fwd: got sel1=%0d sel2=%0d stall=%b expected 2/0/0",
                     ex_rs1_fwd_sel, ex_rs2_fwd_sel, stall);
        end
        next_cycle();
    endtask

    task automatic test_x0();
        drain();
        drive_id(1'b1, 3, 1'b1, 0, 1'b0, 0, 1'b1, 1'b1);      // lw x0 (writes x0)
        next_cycle();
        drive_id(1'b1, 0, 1'b1, 0, 1'b1, 4, 1'b1, 1'b0);      // add x4,x0,x0
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b0 || id_rs1_wb_bypass !== 1'b0 || id_rs2_wb_bypass !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_id: got stall=%b byp=%b%b expected 0/00",
                     stall, id_rs1_wb_bypass, id_rs2_wb_bypass);
        end
        next_cycle();
        drive_id(1'b0, 0, 1'b1, 0, 1'b1, 0, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++;
        if (ex_rs1_fwd_sel !== 2'd0 || ex_rs2_fwd_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL x0_fwd: got sel=%0d/%0d expected 0/0", ex_rs1_fwd_sel, ex_rs2_fwd_sel);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (id_rs1_wb_bypass !== 1'b0 || id_rs2_wb_bypass !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_bypass: got %b%b expected 00", id_rs1_wb_bypass, id_rs2_wb_bypass);
        end
        next_cycle();
    endtask

    task automatic test_redirect();
        for (int variant = 0; variant < 2; variant++) begin
            bit is_ld;
            is_ld = (variant == 0);
            drain();
            drive_id(1'b1, 2, 1'b1, 0, 1'b0, 5, 1'b1, is_ld);  // lw/add x5
            next_cycle();
            drive_id(1'b1, 5, 1'b1, 0, 1'b0, 6, 1'b1, 1'b0);  // use x5
            ex_redirect = 1'b1;
            @(negedge clk);
            n_tests++;
            if (stall !== 1'b0 || flush_d !== 1'b1 || flush_e !== 1'b1) begin
                n_fail++;
                $display("FAIL redirect_%0d: got stall=%b fd=%b fe=%b expected 0/1/1",
                         variant, stall, flush_d, flush_e);
            end
            next_cycle();
            drive_idle();
            @(negedge clk);
            n_tests++;
            if (ex_rs1_fwd_sel !== 2'd0 || flush_d !== 1'b0) begin
                n_fail++;
                $display("FAIL redirect_bubble_%0d: got sel1=%0d fd=%b expected 0/0",
                         variant, ex_rs1_fwd_sel, flush_d);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        drain();
        for (int i = 0; i < 3; i++) begin
            drive_id(1'b1, i + 1, 1'b1, 0, 1'b0, 7, 1'b1, 1'b0);  // add x7
            next_cycle();
        end
        drive_id(1'b1, 7, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0);          // use x7
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b0 || id_rs1_wb_bypass !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_id: got stall=%b byp1=%b expected 0/1", stall, id_rs1_wb_bypass);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_tests++;
        if (ex_rs1_fwd_sel !== 2'd1) begin
            n_fail++; $display("FAIL b2b_youngest: got %0d expected 1", ex_rs1_fwd_sel);
        end
        next_cycle();
    endtask

    task automatic test_reset_midstream();
        drain();
        drive_id(1'b1, 1, 1'b1, 0, 1'b0, 9, 1'b1, 1'b1);      // lw x9
        next_cycle();
        drive_id(1'b1, 9, 1'b1, 9, 1'b1, 10, 1'b1, 1'b0);     // use x9
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: got stall=%b expected 1", stall);
        end
        #1 rst = 1'b0;
        #1;
        n_tests++;
        if ({stall, flush_d, flush_e, id_rs1_wb_bypass, id_rs2_wb_bypass,
             ex_rs1_fwd_sel, ex_rs2_fwd_sel} !== 9'd0 || stall_cnt !== 32'd0
             || flush_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_hold: got stall=%b byp=%b%b cnt=%0d/%0d expected all 0",
                     stall, id_rs1_wb_bypass, id_rs2_wb_bypass, stall_cnt, flush_cnt);
        end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (stall !== 1'b0 || id_rs1_wb_bypass !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_stall: got stall=%b byp1=%b expected 0/0", stall, id_rs1_wb_bypass);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_tests++;
        if (ex_rs1_fwd_sel !== 2'd0 || ex_rs2_fwd_sel !== 2'd0
            || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_after: got sel=%0d/%0d cnt=%0d/%0d expected 0/0 0/0",
                     ex_rs1_fwd_sel, ex_rs2_fwd_sel, stall_cnt, flush_cnt);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [8:0] act, exp;
        int exp_sc, exp_fc;
        for (int c = 0; c < 400; c++) begin
            drive_id($urandom_range(0, 99) < 85,
                     int'($urandom_range(0, 3)), $urandom_range(0, 99) < 80,
                     int'($urandom_range(0, 3)), $urandom_range(0, 99) < 80,
                     int'($urandom_range(0, 3)), $urandom_range(0, 99) < 80,
                     $urandom_range(0, 99) < 30);
            ex_redirect = ($urandom_range(0, 99) < 8);
            @(negedge clk);
            act = {stall, flush_d, flush_e, id_rs1_wb_bypass, id_rs2_wb_bypass,
                   ex_rs1_fwd_sel, ex_rs2_fwd_sel};
            exp = {m_stall(), ex_redirect, ex_redirect, m_bypass(1'b0), m_bypass(1'b1),
                   2'(m_ex_sel(1'b0)), 2'(m_ex_sel(1'b1))};
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL random_c%0d: got %b expected %b (stall,fd,fe,byp1,byp2,sel1,sel2)",
                         c, act, exp);
            end
`ifdef HAZARD_PERF_EN
            exp_sc = m_stall_cnt;
            exp_fc = m_flush_cnt;
`else
            exp_sc = 0;
            exp_fc = 0;
`endif
            n_tests++;
            if (stall_cnt !== 32'(exp_sc) || flush_cnt !== 32'(exp_fc)) begin
                n_fail++;
                $display("FAIL random_cnt_c%0d: got %0d/%0d expected %0d/%0d",
                         c, stall_cnt, flush_cnt, exp_sc, exp_fc);
            end
            next_cycle();
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_load_use();
        test_x0();
        test_redirect();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipe_hazard_unit
`default_nettype wire

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter REG_IDX_W, default 5, meaning the register index width.
REQ-002 SHALL have parameter FWD_STAGES, default 2, meaning the number of post-EXE stages that can forward (slot 1..FWD_STAGES; the last slot is WB).
REQ-003 SHALL have parameter LD_AVAIL_STAGE, default 2, meaning the first slot whose load data is forwardable; legal range 1..FWD_STAGES.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst as elsewhere in the codebase.
REQ-005 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  async active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1_idx, id_rs2_idx  in  REG_IDX_W  ID source indices.
- id_rs1_used, id_rs2_used  in  1  source actually read.
- id_rd_idx  in  REG_IDX_W  ID destination.
- id_rd_wen  in  1  ID writes rd.
- id_is_load  in  1  ID is a load.
- ex_redirect  in  1  taken branch or jump resolved in EXE.
- stall  out  1  hold PC and the D register; bubble into E.
- flush_d, flush_e  out  1  invalidate the D and E registers.
- id_rs1_wb_bypass, id_rs2_wb_bypass  out  1  select WB data over the regfile in ID.
- ex_rs1_fwd_sel, ex_rs2_fwd_sel  out  $clog2(FWD_STAGES+1)  0 = no forward, k = slot k.
- stall_cnt, flush_cnt  out  32  performance counters (see REQ-019).

Function
REQ-006 SHALL keep a slot pipeline: slot 0 = EXE, slots 1..FWD_STAGES = downstream stages; each slot holds valid, rd, wen, is_load; slot 0 also holds rs1/rs2 indices and used flags.
REQ-007 SHALL shift slot k-1 into slot k every clock unconditionally; slot FWD_STAGES retires.
REQ-008 SHALL load slot 0 from the ID inputs each clock, except that it loads a bubble (valid=0) when stall, ex_redirect, or !id_valid is true.
REQ-009 SHALL treat a producer as matching only when valid, wen, rd equals the source index, rd != 0, and the source is marked used.
REQ-010 SHALL drive ex_rsN_fwd_sel to the lowest-numbered matching slot among 1..FWD_STAGES against the slot 0 sources, and to 0 when none matches or slot 0 is invalid.
REQ-011 SHALL assert stall when id_valid, no ex_redirect, and the youngest producer matching an ID source sits in slot s with is_load and s+1 < LD_AVAIL_STAGE; with the default parameters a load in EXE produces exactly one stall cycle.
REQ-012 SHALL assert id_rsN_wb_bypass when slot FWD_STAGES matches the ID source.
REQ-013 SHALL drive flush_d = flush_e = ex_redirect, and SHALL force stall to 0 while ex_redirect is high (redirect wins).
REQ-014 SHALL compute all outputs combinationally from the slots and inputs, with 0 latency; slot state updates on posedge clk.
REQ-015 SHALL compute back-to-back dependencies on the same rd from the youngest producer only.

Reset
REQ-016 SHALL, while rst is low, asynchronously clear all slot valid bits and both counters; all outputs read 0.
REQ-017 SHALL, after reset is asserted mid-operation, forget in-flight producers, so that no forward or stall references pre-reset state.

Configuration
REQ-018 SHALL be controlled by the macro HAZARD_PERF_EN.
REQ-019 SHALL, with HAZARD_PERF_EN defined, increment stall_cnt on each cycle with stall=1 and flush_cnt on each cycle with ex_redirect=1, each wrapping at 2^32; without the macro, both outputs are tied to 0 and no counter flops exist.

Structure
REQ-020 SHALL place the slot struct typedef, the FWD_NONE=0 constant and the index-width default in the shared package hazard_pkg.
REQ-021 SHALL implement the per-source youngest-match priority search in one sub-module, hazard_fwd_match, instantiated four times (2 EXE sources, 2 ID sources).

Verification
REQ-022 SHALL cover: add x5 then next-cycle add x6,x5,x1 -> ex_rs1_fwd_sel=1 for one cycle, no stall.
REQ-023 SHALL cover: lw x5 then next-cycle add x6,x5,x0 -> stall=1 for exactly 1 cycle, then ex_rs1_fwd_sel=2.
REQ-024 SHALL cover: add x0,... then use of x0 -> fwd_sel=0, no stall, no bypass.
REQ-025 SHALL cover: lw x5 in EXE with ID using x5 and ex_redirect=1 in the same cycle -> stall=0, flush_d=flush_e=1, slot 0 bubble next cycle.
REQ-026 SHALL cover: writes to x7 in three consecutive instructions, then a use of x7 -> fwd_sel=1 (youngest producer).
REQ-027 SHALL cover: rst pulled low mid-stream, then released, then a use of a pre-reset rd -> no forward or stall; with HAZARD_PERF_EN, both counters read 0.
